tgate_sel_ctrl: RTL and testbench

// - Break-before-make select sequencer directly upstream of the transmission-gate switch array.
// - Drives the per-channel gate controls: sel to the NMOS gates, sel_n to the PMOS gates.
// - Accepts channel-switch requests over a valid/ready handshake.
// - Guarantees that at most one channel conducts at any time.
// - Inserts a programmable all-off dead time before a new channel is closed.

---
 rtl/tgate_sel_ctrl_if.sv | 27 ++
 rtl/tgate_sel_ctrl.sv | 122 ++++++++++++
 tb/tb_tgate_sel_ctrl.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/tgate_sel_ctrl_if.sv
// Request handshake and gate-drive bundle between a channel-switch
// requester (master) and the tgate select sequencer (slave).
interface tgate_sel_ctrl_if #(
    parameter int N_CH  = 4,
    parameter int SEL_W = 2
);
    logic             req_valid;
    logic [SEL_W-1:0] req_ch;
    logic             req_ready;
    logic [N_CH-1:0]  sel;
    logic [N_CH-1:0]  sel_n;
    logic             active_valid;
    logic [SEL_W-1:0] active_ch;
    logic             busy;

    modport master (
        output req_valid, req_ch,
        input  req_ready, sel, sel_n,
        input  active_valid, active_ch, busy
    );

    modport slave (
        input  req_valid, req_ch,
        output req_ready, sel, sel_n,
        output active_valid, active_ch, busy
    );
endinterface

// File: rtl/tgate_sel_ctrl.sv
// Break-before-make select sequencer feeding a tgate switch array.
// Define TGSEL_MIN_ON_EN to enforce a MIN_ON-cycle minimum closed time.
module tgate_sel_ctrl #(
    parameter int N_CH     = 4,
    parameter int SEL_W    = 2,
    parameter int DEAD_CYC = 2,
    parameter int MIN_ON   = 3
) (
    input logic             clk,
    input logic             rst,
    tgate_sel_ctrl_if.slave bus
);
    localparam int DW = (DEAD_CYC > 1) ? $clog2(DEAD_CYC) : 1;
    localparam logic [SEL_W:0] NLIM = (SEL_W+1)'(N_CH);
    localparam logic [N_CH-1:0] ONE = {{(N_CH-1){1'b0}}, 1'b1};

    if (N_CH < 2 || DEAD_CYC < 1 || MIN_ON < 1) begin : g_bad_cfg
        $error("tgate_sel_ctrl: illegal parameters");
    end

    typedef enum logic [1:0] {
        S_OFF,
        S_BREAK,
        S_ON
    } state_t;

    state_t           state;
    logic [N_CH-1:0]  sel_q;
    logic [SEL_W-1:0] tgt;
    logic [SEL_W-1:0] act_ch;
    logic             act_v;
    logic             busy_q;
    logic             rdy_q;
    logic [DW-1:0]    dcnt;
    logic             acc;
    logic             in_rng;
    logic             same;
    logic [N_CH-1:0]  tgt_oh;

`ifdef TGSEL_MIN_ON_EN
    localparam int MW = (MIN_ON > 1) ? $clog2(MIN_ON) : 1;
    logic [MW-1:0] mcnt;
`endif

    assign acc    = bus.req_valid && rdy_q;
    assign in_rng = {1'b0, bus.req_ch} < NLIM;
    assign same   = (state == S_ON) && (bus.req_ch == act_ch);
    assign tgt_oh = ONE << tgt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= S_OFF;
            sel_q  <= '0;
            tgt    <= '0;
            act_ch <= '0;
            act_v  <= 1'b0;
            busy_q <= 1'b0;
            rdy_q  <= 1'b1;
            dcnt   <= '0;
`ifdef TGSEL_MIN_ON_EN
            mcnt   <= '0;
`endif
        end else begin
            unique case (state)
                S_BREAK: begin
                    if (dcnt == '0) begin
                        state  <= S_ON;
                        sel_q  <= tgt_oh;
                        act_ch <= tgt;
                        act_v  <= 1'b1;
                        busy_q <= 1'b0;
`ifdef TGSEL_MIN_ON_EN
                        rdy_q  <= 1'b0;
                        mcnt   <= MW'(MIN_ON - 1);
`else
                        rdy_q  <= 1'b1;
`endif
                    end else begin
                        dcnt <= dcnt - 1'b1;
                    end
                end
                S_OFF, S_ON: begin
`ifdef TGSEL_MIN_ON_EN
                    if (!rdy_q) begin
                        if (mcnt == '0) rdy_q <= 1'b1;
                        else            mcnt  <= mcnt - 1'b1;
                    end
`endif
                    // Opening is always safe, so out-of-range skips dead time.
                    if (acc && !in_rng) begin
                        state  <= S_OFF;
                        sel_q  <= '0;
                        act_ch <= '0;
                        act_v  <= 1'b0;
                    end else if (acc && !same) begin
                        state  <= S_BREAK;
                        sel_q  <= '0;
                        tgt    <= bus.req_ch;
                        act_ch <= '0;
                        act_v  <= 1'b0;
                        busy_q <= 1'b1;
                        rdy_q  <= 1'b0;
                        dcnt   <= DW'(DEAD_CYC - 1);
                    end
                end
                default: begin
                    state <= S_OFF;
                    sel_q <= '0;
                    act_v <= 1'b0;
                    rdy_q <= 1'b1;
                end
            endcase
        end
    end

    assign bus.sel          = sel_q;
    assign bus.sel_n        = ~sel_q;
    assign bus.req_ready    = rdy_q;
    assign bus.active_valid = act_v;
    assign bus.active_ch    = act_ch;
    assign bus.busy         = busy_q;
endmodule

// File: tb/tb_tgate_sel_ctrl.sv
// Bench for tgate_sel_ctrl: 4- and 3-channel instances share one request
// stream and are compared against an event-level model of the sequencer.
module tb_tgate_sel_ctrl;
    localparam int DEAD  = 2;
    localparam int MINON = 3;
`ifdef TGSEL_MIN_ON_EN
    localparam bit MON = 1'b1;
`else
    localparam bit MON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       rv;
    logic [1:0] rc;

    always #5 clk = ~clk;

    tgate_sel_ctrl_if #(.N_CH(4), .SEL_W(2)) b0 ();
    tgate_sel_ctrl_if #(.N_CH(3), .SEL_W(2)) b1 ();

    assign b0.req_valid = rv;
    assign b0.req_ch    = rc;
    assign b1.req_valid = rv;
    assign b1.req_ch    = rc;

    tgate_sel_ctrl #(.N_CH(4), .SEL_W(2), .DEAD_CYC(DEAD), .MIN_ON(MINON))
        u0 (.clk(clk), .rst(rst), .bus(b0));
    tgate_sel_ctrl #(.N_CH(3), .SEL_W(2), .DEAD_CYC(DEAD), .MIN_ON(MINON))
        u1 (.clk(clk), .rst(rst), .bus(b1));

    int checks = 0;
    int errors = 0;

    // Model: closed channel (-1 = none), pending target, remaining
    // all-off cycles, remaining minimum-on cycles.
    int nch[2] = '{4, 3};
    int m_cur[2];
    int m_tgt[2];
    int m_dead[2];
    int m_hold[2];

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic mreset();
        for (int i = 0; i < 2; i++) begin
            m_cur[i]  = -1;
            m_tgt[i]  = 0;
            m_dead[i] = 0;
            m_hold[i] = 0;
        end
    endtask

    task automatic mstep(logic v, logic [1:0] ch);
        bit acc;
        for (int i = 0; i < 2; i++) begin
            acc = v && m_dead[i] == 0 && m_hold[i] == 0;
            if (m_dead[i] > 0) begin
                m_dead[i]--;
                if (m_dead[i] == 0) begin
                    m_cur[i]  = m_tgt[i];
                    m_hold[i] = MON ? MINON : 0;
                end
            end else if (m_hold[i] > 0) begin
                m_hold[i]--;
            end else if (acc) begin
                if (int'(ch) >= nch[i]) begin
                    m_cur[i] = -1;
                end else if (int'(ch) != m_cur[i]) begin
                    m_cur[i]  = -1;
                    m_tgt[i]  = int'(ch);
                    m_dead[i] = DEAD;
                end
            end
        end
    endtask

    task automatic check_one(int i, string t, logic [31:0] sel,
                             logic [31:0] sn, logic rdy, logic av,
                             logic [31:0] ac, logic bz);
        logic [31:0] mask;
        logic [31:0] es;
        mask = (32'd1 << nch[i]) - 32'd1;
        es   = (m_cur[i] < 0) ? 32'd0 : (32'd1 << m_cur[i]);
        chk($sformatf("%s/u%0d/sel", t, i), sel, es);
        chk($sformatf("%s/u%0d/sel_n", t, i), sn, ~es & mask);
        chk($sformatf("%s/u%0d/onehot", t, i),
            32'($countones(sel) <= 1), 32'd1);
        chk($sformatf("%s/u%0d/ready", t, i), 32'(rdy),
            32'(m_dead[i] == 0 && m_hold[i] == 0));
        chk($sformatf("%s/u%0d/busy", t, i), 32'(bz), 32'(m_dead[i] > 0));
        chk($sformatf("%s/u%0d/act_v", t, i), 32'(av), 32'(m_cur[i] >= 0));
        chk($sformatf("%s/u%0d/act_ch", t, i), ac,
            (m_cur[i] < 0) ? 32'd0 : 32'(m_cur[i]));
    endtask

    task automatic check_all(string t);
        check_one(0, t, 32'(b0.sel), 32'(b0.sel_n), b0.req_ready,
                  b0.active_valid, 32'(b0.active_ch), b0.busy);
        check_one(1, t, 32'(b1.sel), 32'(b1.sel_n), b1.req_ready,
                  b1.active_valid, 32'(b1.active_ch), b1.busy);
    endtask

    task automatic cyc(logic v, logic [1:0] ch, string t);
        rv = v;
        rc = ch;
        @(posedge clk);
        mstep(v, ch);
        @(negedge clk);
        check_all(t);
    endtask

    task automatic hold_req(logic [1:0] ch, int n, string t);
        for (int k = 0; k < n; k++) cyc(1'b1, ch, t);
    endtask

    task automatic async_rst(string t);
        #2 rst = 1'b1;
        mreset();
        #1 check_all(t);
        @(negedge clk);
        check_all({t, "_held"});
        rst = 1'b0;
    endtask

    initial begin
        rv  = 1'b0;
        rc  = 2'd0;
        rst = 1'b1;
        mreset();
        repeat (2) @(negedge clk);
        check_all("reset");
        rst = 1'b0;

        cyc(1'b1, 2'd2, "off_to_ch2_acc");
        cyc(1'b0, 2'd0, "off_to_ch2_dead");
        cyc(1'b0, 2'd0, "off_to_ch2_on");
        repeat (MINON + 1) cyc(1'b0, 2'd0, "ch2_idle");

        hold_req(2'd1, 1, "ch2_to_ch1_acc");
        hold_req(2'd1, 1, "ch2_to_ch1_dead");
        hold_req(2'd1, 1, "ch2_to_ch1_on");
        hold_req(2'd1, MINON + 2, "ch1_same");

        hold_req(2'd3, 1, "req_ch3_acc");
        async_rst("midbreak_rst");
        repeat (4) cyc(1'b0, 2'd0, "after_rst");

        hold_req(2'd0, DEAD + 1, "off_to_ch0");
        hold_req(2'd1, MINON + DEAD + 2, "minon_held");
        repeat (2) cyc(1'b0, 2'd0, "minon_idle");
        async_rst("on_rst");

        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(63) == 0) begin
                @(negedge clk);
                async_rst("rand_rst");
            end else begin
                cyc(1'($urandom_range(1)), 2'($urandom_range(3)), "rand");
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
